alu_arbiter: RTL

Shares one `alu32` instance between two requesters: the main single-cycle datapath and the complex-instruction microsequencer. Each requester offers a valid/ready request carrying operands and a 3-bit ALU control code. The block grants one request at a time by round-robin, drives the shared ALU from registered operands, and captures the ALU flags into a single response channel. The response is tagged with the requester ID and held until it is accepted.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one alu32 instance.
// Requests are granted one at a time. The operands are registered, the ALU
// evaluates them for one cycle, and the result and flags are held as a
// tagged response until it is accepted.
// Compile-time option: ALU_ARB_FIXED_PRIO_EN selects fixed priority, where
// requester 0 always wins. Without it the arbiter uses round-robin.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_gin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_gin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_zout,
  output logic              rsp_nout,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_gin,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic              alu_zout,
  input  logic              alu_nout,
  input  logic              alu_overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] GIN_ILLEGAL = 3'b101;
  localparam logic [2:0] GIN_ADD     = 3'b010;

  logic [1:0]        state;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_gin;
  logic              op_id;
  logic              gnt0;
  logic              gnt1;
  logic              accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic              last_id;
`endif

  // Pick a winner among the valid requesters. The result only matters in IDLE.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      gnt0 = last_id;
      gnt1 = ~last_id;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
`endif
  end

  assign req0_ready = rst_n & (state == IDLE) & gnt0;
  assign req1_ready = rst_n & (state == IDLE) & gnt1;
  assign accept     = req0_ready | req1_ready;

  // The ALU is always driven from the operand registers, so its inputs stay stable in every state.
  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_gin = op_gin;

  // Sequencer: accept a request, run one EXEC cycle, then hold the response until it is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      op_gin       <= GIN_ADD;
      op_id        <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_id      <= 1'b1;
`endif
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_zout     <= 1'b0;
      rsp_nout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= req1_ready ? req1_a : req0_a;
            op_b    <= req1_ready ? req1_b : req0_b;
            op_gin  <= req1_ready ? req1_gin : req0_gin;
            op_id   <= req1_ready;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_id <= req1_ready;
`endif
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (op_gin == GIN_ILLEGAL) begin
            rsp_sum      <= '0;
            rsp_zout     <= 1'b0;
            rsp_nout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b1;
          end else begin
            rsp_sum      <= alu_sum;
            rsp_zout     <= alu_zout;
            rsp_nout     <= alu_nout;
            rsp_overflow <= alu_overflow;
            rsp_err      <= 1'b0;
          end
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
